// File: rtl/pc_ctrl.sv
// Next-PC/fetch controller with branch-target LUT and IDLE/RUN/DONE sequencing; next PC one cycle after inputs, no bubble on taken branches.
// Backpressure: stall freezes pc, br_cnt and state in RUN; LUT writes proceed regardless.
module pc_ctrl #(
   parameter int PC_W   = 10,
   parameter int LUT_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [PC_W-1:0]   start_addr,
   input  logic              stall,
   input  logic              halt_i,
   input  logic              branch_en,
   input  logic              taken,
   input  logic [LUT_AW-1:0] tgt_idx,
   input  logic              lut_we,
   input  logic [LUT_AW-1:0] lut_waddr,
   input  logic [PC_W-1:0]   lut_wdata,
   output logic [PC_W-1:0]   pc,
   output logic              fetch_valid,
   output logic              done,
   output logic [7:0]        br_cnt
);

   localparam int LUT_N = 2 ** LUT_AW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [7:0]        br_cnt_q, br_cnt_d;
   logic [PC_W-1:0]   lut [LUT_N];
   logic [PC_W-1:0]   br_tgt;

   // Combinational read sees the pre-write entry on a same-edge write+branch.
   assign br_tgt = lut[tgt_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         br_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         br_cnt_q <= br_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LUT_N; i++) begin
            lut[i] <= '0;
         end
      end else if (lut_we) begin
         lut[lut_waddr] <= lut_wdata;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      br_cnt_d = br_cnt_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = RUN;
               pc_d     = start_addr;
               br_cnt_d = '0;
            end
         end
         RUN: begin
            if (start) begin
               pc_d     = start_addr;
               br_cnt_d = '0;
            end else if (stall) begin
               state_d = RUN;
            end else if (halt_i) begin
               // pc stays on the halt instruction; a coincident taken branch is dropped
               state_d = DONE;
            end else if (branch_en && taken) begin
               pc_d     = br_tgt;
               br_cnt_d = (br_cnt_q == 8'hFF) ? br_cnt_q : br_cnt_q + 8'd1;
            end else begin
               pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      pc          = pc_q;
      br_cnt      = br_cnt_q;
      fetch_valid = (state_q == RUN);
      done        = (state_q == DONE);
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_ctrl;

   localparam int PC_W   = 10;
   localparam int LUT_AW = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start;
   logic [PC_W-1:0]   start_addr;
   logic              stall;
   logic              halt_i;
   logic              branch_en;
   logic              taken;
   logic [LUT_AW-1:0] tgt_idx;
   logic              lut_we;
   logic [LUT_AW-1:0] lut_waddr;
   logic [PC_W-1:0]   lut_wdata;
   logic [PC_W-1:0]   pc;
   logic              fetch_valid;
   logic              done;
   logic [7:0]        br_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: running flag, halted flag, integer pc/count, target table.
   bit m_run, m_halted;
   int m_pc, m_cnt;
   int m_lut [32];

   pc_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .start_addr  (start_addr),
      .stall       (stall),
      .halt_i      (halt_i),
      .branch_en   (branch_en),
      .taken       (taken),
      .tgt_idx     (tgt_idx),
      .lut_we      (lut_we),
      .lut_waddr   (lut_waddr),
      .lut_wdata   (lut_wdata),
      .pc          (pc),
      .fetch_valid (fetch_valid),
      .done        (done),
      .br_cnt      (br_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_halted = 0; m_pc = 0; m_cnt = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
   endtask

   task automatic model_edge();
      int tgt;
      tgt = m_lut[tgt_idx];
      if (start) begin
         m_run = 1; m_halted = 0; m_pc = start_addr; m_cnt = 0;
      end else if (m_run && !stall) begin
         if (halt_i) begin
            m_run = 0; m_halted = 1;
         end else if (branch_en && taken) begin
            m_pc  = tgt;
            m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
         end else begin
            m_pc = (m_pc + 1) % (1 << PC_W);
         end
      end
      if (lut_we) m_lut[lut_waddr] = lut_wdata;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"},     32'(pc),          32'(m_pc));
      check({tag, ".fv"},     32'(fetch_valid), 32'(m_run));
      check({tag, ".done"},   32'(done),        32'(m_halted));
      check({tag, ".br_cnt"}, 32'(br_cnt),      32'(m_cnt));
   endtask

   task automatic quiet();
      start = 0; start_addr = '0; stall = 0; halt_i = 0; branch_en = 0; taken = 0;
      tgt_idx = '0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
   endtask

   // Advance one edge, update the model, then sample just after the edge.
   task automatic step(input string tag);
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      quiet();
      model_reset();
      #2;
      check_all("por");
      #10 rst_n = 1'b1;

      // T1: async reset mid-RUN
      start = 1; start_addr = 10'h1F3;
      step("t1_start");
      start = 0;
      check("t1_pc_before", 32'(pc), 32'h1F3);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("t1_pc", 32'(pc), 32'h0);
      check("t1_fv", 32'(fetch_valid), 32'h0);
      check("t1_done", 32'(done), 32'h0);
      check("t1_cnt", 32'(br_cnt), 32'h0);
      #2 rst_n = 1'b1;

      // T2: sequential fetch with wrap
      start = 1; start_addr = 10'h3FE;
      step("t2_a");
      start = 0;
      check("t2_pc0", 32'(pc), 32'h3FE);
      step("t2_b"); check("t2_pc1", 32'(pc), 32'h3FF);
      step("t2_c"); check("t2_pc2", 32'(pc), 32'h000);
      step("t2_d"); check("t2_pc3", 32'(pc), 32'h001);

      // T3: taken and not-taken branch
      start = 1; start_addr = 10'h010; lut_we = 1; lut_waddr = 5'd5; lut_wdata = 10'h040;
      step("t3_a");
      start = 0; lut_we = 0;
      branch_en = 1; taken = 1; tgt_idx = 5'd5;
      step("t3_b");
      check("t3_tk_pc", 32'(pc), 32'h040);
      check("t3_tk_cnt", 32'(br_cnt), 32'd1);
      taken = 0;
      step("t3_c");
      check("t3_nt_pc", 32'(pc), 32'h041);
      branch_en = 0;

      // T4: stall beats halt, then halt; then saturation
      stall = 1; halt_i = 1;
      step("t4_a");
      check("t4_stall_fv", 32'(fetch_valid), 32'd1);
      check("t4_stall_pc", 32'(pc), 32'h041);
      stall = 0;
      step("t4_b");
      check("t4_halt_done", 32'(done), 32'd1);
      check("t4_halt_pc", 32'(pc), 32'h041);
      halt_i = 0;
      start = 1; start_addr = 10'h080;
      step("t6_a");
      start = 0;
      check("t6_fv", 32'(fetch_valid), 32'd1);
      check("t6_done", 32'(done), 32'd0);
      check("t6_pc", 32'(pc), 32'h080);
      check("t6_cnt", 32'(br_cnt), 32'd0);
      branch_en = 1; taken = 1; tgt_idx = 5'd5;
      for (int i = 0; i < 256; i++) step("t4_sat");
      check("t4_sat_cnt", 32'(br_cnt), 32'd255);
      step("t4_sat2");
      check("t4_sat_hold", 32'(br_cnt), 32'd255);
      branch_en = 0; taken = 0;

      // T5: same-edge write and branch reads the old entry
      lut_we = 1; lut_waddr = 5'd3; lut_wdata = 10'h020;
      step("t5_a");
      lut_wdata = 10'h100; branch_en = 1; taken = 1; tgt_idx = 5'd3;
      step("t5_b");
      check("t5_old", 32'(pc), 32'h020);
      lut_we = 0;
      step("t5_c");
      check("t5_new", 32'(pc), 32'h100);

      // Halt wins over taken branch; DONE ignores everything but start
      halt_i = 1;
      step("hb_a");
      check("hb_cnt", 32'(br_cnt), 32'd255);
      check("hb_pc", 32'(pc), 32'h100);
      halt_i = 0; stall = 1;
      step("hb_b");
      stall = 0; branch_en = 1; taken = 1;
      step("hb_c");
      check("done_hold_pc", 32'(pc), 32'h100);
      branch_en = 0; taken = 0;
      start = 1; start_addr = 10'h080;
      step("t6_b");
      check("t6_restart_pc", 32'(pc), 32'h080);
      start_addr = 10'h2AA;
      step("t6_c");
      start = 0;
      check("t6_run_restart", 32'(pc), 32'h2AA);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         start      = ($urandom_range(0, 39) == 0);
         start_addr = PC_W'($urandom);
         stall      = ($urandom_range(0, 4) == 0);
         halt_i     = ($urandom_range(0, 29) == 0);
         branch_en  = ($urandom_range(0, 2) == 0);
         taken      = $urandom_range(0, 1) == 1;
         tgt_idx    = LUT_AW'($urandom);
         lut_we     = ($urandom_range(0, 3) == 0);
         lut_waddr  = LUT_AW'($urandom);
         lut_wdata  = PC_W'($urandom);
         step("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
